// File: rtl/operand_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : operand_skew_feeder
// Description : West-edge operand feeder for an output-stationary PE array.
//               Takes one column of N operands per handshake beat and drives
//               lane i through i+1 registers, so each row sees its element i
//               cycles after row 0. Frames one tile of K beats: a one-cycle
//               psum_clr aligned with the first element in lane 0, zero
//               bubbles when the source stalls, a drain phase that flushes
//               the skew, and a one-cycle done pulse at the end.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               in_valid/ready  - source handshake, in_ready is registered
//               in_data         - N*W column, lane i on [i*W +: W]
//               lane_data/valid - skewed operands and their valid flags
//               psum_clr        - accumulator clear for the tile's first cycle
//               busy, done      - tile in progress / tile fully emitted
// Revision    : 1.0 - initial release
// ============================================================================
module operand_skew_feeder #(
    parameter int N = 4,
    parameter int W = 32,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    output logic [N*W-1:0] lane_data,
    output logic [N-1:0]   lane_valid,
    output logic           psum_clr,
    output logic           busy,
    output logic           done
);

    localparam int BW = $clog2(K + 1);
    localparam int DW = $clog2(N);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(K);
    // DRAIN lasts N-1 cycles; the count starts at 0 on entry.
    localparam logic [DW-1:0] DRAIN_LAST = DW'(N - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_cnt_next;
    logic [BW-1:0] beat_cnt_inc;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_cnt_next;
    logic          accept;

    assign accept       = in_valid && in_ready;
    assign beat_cnt_inc = beat_cnt + BW'(1);

    always_comb begin
        next_state     = state;
        beat_cnt_next  = beat_cnt;
        drain_cnt_next = drain_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    beat_cnt_next  = BW'(1);
                    drain_cnt_next = '0;
                    next_state     = (K == 1) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    beat_cnt_next = beat_cnt_inc;
                    if (beat_cnt_inc == BEAT_LAST) begin
                        next_state     = DRAIN;
                        drain_cnt_next = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = DONE;
                end else begin
                    drain_cnt_next = drain_cnt + DW'(1);
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            in_ready  <= 1'b0;
            psum_clr  <= 1'b0;
        end else begin
            state     <= next_state;
            beat_cnt  <= beat_cnt_next;
            drain_cnt <= drain_cnt_next;
            // Registered ready follows the state being entered, so it falls
            // on the edge taking the last beat and rises on leaving DONE.
            in_ready  <= (next_state == IDLE) || (next_state == LOAD);
            // Lane 0 shows beat 0 in the cycle after its accept edge.
            psum_clr  <= accept && (state == IDLE);
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Lane i: i+1 stage shift chain. Non-accept cycles feed zero bubbles.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] sdata  [0:i];
        logic         svalid [0:i];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    sdata[j]  <= '0;
                    svalid[j] <= 1'b0;
                end
            end else begin
                sdata[0]  <= accept ? in_data[i*W +: W] : '0;
                svalid[0] <= accept;
                for (int j = 1; j <= i; j++) begin
                    sdata[j]  <= sdata[j-1];
                    svalid[j] <= svalid[j-1];
                end
            end
        end

        assign lane_data[i*W +: W] = sdata[i];
        assign lane_valid[i]       = svalid[i];
    end

endmodule
`default_nettype wire

// File: doc/operand_skew_feeder.md
# operand_skew_feeder

Upstream feeder for the output-stationary PE array. Accepts one column of operands per handshake beat (one element per array row) and drives them into the array's west edge with a diagonal skew (row i delayed i cycles), so the data wavefronts reach each OSPE row in the correct order. It frames one tile of K beats: it asserts a partial-sum clear aligned with the first element, inserts zero bubbles when the source stalls, drains the skew, and pulses done when the last element has left every lane.

## Interface
- N, 4, number of lanes (array rows); N >= 2
- W, 32, operand width in bits
- K, 4, beats per tile (inner dimension); K >= 1
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  source has a beat on in_data
- in_ready  output  1  feeder accepts a beat this cycle
- in_data  input  N*W  lane i element on bits [i*W +: W]
- lane_data  output  N*W  skewed operands to the array, lane i on bits [i*W +: W]
- lane_valid  output  N  lane i carries a real element (not a bubble)
- psum_clr  output  1  one-cycle tile-start clear for the PE accumulators
- busy  output  1  tile in progress (state != IDLE)
- done  output  1  one-cycle pulse: tile fully emitted

## Operation
- Beat accepted on a rising edge where in_valid && in_ready. All outputs are registered.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: in_ready=1. Accepted beat -> LOAD, beat_cnt=1; if K==1 go directly to DRAIN.
- LOAD: in_ready=1. Each accepted beat increments beat_cnt; the beat that makes beat_cnt==K moves to DRAIN with drain_cnt=0. Cycles with no accepted beat inject a bubble (zero data, valid low) into lane 0's stream.
- DRAIN: in_ready=0; bubbles injected; drain_cnt increments each cycle; after N-1 cycles -> DONE.
- DONE: in_ready=0; done=1 for this single cycle; -> IDLE.
- Skew: lane i is a shift chain of i+1 registers (data plus valid). Lane 0 chain is loaded from in_data[0 +: W] on accept; lane i chain input is in_data[i*W +: W] on accept, zero otherwise.
- Bubbles are data zero, so a PE that multiplies on every edge adds nothing; lane_valid is for monitoring.
- psum_clr: high in the cycle in which lane 0 presents the tile's first element, i.e. the cycle following the accept edge of beat 0. No other cycle.
- busy = (state != IDLE).
- Arithmetic: no data transform; widths pass through unchanged. beat_cnt is clog2(K+1) bits, drain_cnt is clog2(N) bits, with no wrap inside a tile.

## Timing
- Reset (rst high at an edge): state IDLE, every skew register 0, lane_data=0, lane_valid=0, psum_clr=0, done=0, busy=0. in_ready=1 from the cycle after reset releases.
- Reset mid-tile: the tile is aborted with no done pulse; the skew chains are zeroed in the same edge.
- Latency: if beat k (0-based) is accepted on edge E, lane i shows it from edge E+i to edge E+i+1, with lane_valid[i]=1.
- No stalls: K beats on consecutive edges E..E+K-1. The last element leaves lane N-1 at edge E+K+N-2, and done is high from that edge for one cycle.
- in_ready drops on the edge that accepts beat K-1. It returns high the edge after the done cycle, so the next tile's beat 0 can be accepted at the edge ending the done cycle plus one.
- in_valid while in_ready=0: ignored; the source must hold its data.
- Source stall in LOAD: the tile lengthens by the stall count. The bubble propagates diagonally, and done is delayed by the same count.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 -> all outputs 0, no beat consumed; in_ready=1 after release.
- Back-to-back tile, N=4, K=4: lane i beat k = 16*i+k+1, valid every cycle from edge E.
  - lane 2 emits 33,34,35,36 on edges E+2..E+5.
  - psum_clr is high only in the cycle after E.
  - done is high exactly at E+6.
- Mid-tile stall: drop in_valid for 2 cycles after beat 1 -> every lane shows 2 zero cycles with lane_valid=0 between elements 2 and 3; done moves to E+8.
- Back-pressure: hold in_valid=1 through DRAIN/DONE with changing in_data -> no extra beats are taken, and the next tile begins only after done.
- Reset mid-tile: assert rst after beat 2 -> all lanes are 0 next cycle, done is never pulsed, and a fresh tile then completes normally.
- K=1 corner: a single beat -> psum_clr and lane 0 data appear in the same cycle, and done follows N-1 cycles later.
